// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus one carry flop, LSB first, WIDTH+2 cycles per result.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bit_s, carry_s, last_s;

  assign bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_s = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_s  = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        carry_d = carry_s;
        if (last_s) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // After the last shift the carry flop already holds the carry out of the MSB.
  assign sum  = sum_q;
  assign cout = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == SHIFT && last_s) ovf_d = carry_q ^ carry_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder (WIDTH=8), plus hand-written reset, re-start and back-to-back sequences.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  int           r_lat, r_busy, r_done;
  logic [W-1:0] r_sum, r_hold;
  logic         r_cout, r_ovf;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Call at a negedge with the DUT idle; returns at a negedge 14 cycles after acceptance.
  // k counts negedges after the accepting posedge, so done at k=9 is 9 cycles after acceptance.
  task automatic op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc, input bit disturb);
    start = 1'b1; a = va; b = vb; cin = vc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = ~vc;
    r_lat = 0; r_busy = 0; r_done = 0;
    r_sum = '0; r_cout = 1'b0; r_ovf = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) r_busy++;
      if (done) begin
        r_done++;
        if (r_lat == 0) begin
          r_lat = k; r_sum = sum; r_cout = cout; r_ovf = ovf;
        end
      end
      if (disturb) begin
        start = (k >= 2 && k <= 6);
        a = W'($urandom); b = W'($urandom);
      end
    end
    r_hold = sum;
  endtask

  task automatic check_op(input string tag, input vec_t v);
    chk({tag, " sum"}, r_sum, v.s);
    chk({tag, " cout"}, r_cout, v.co);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, " ovf"}, r_ovf, v.ov);
`endif
    chk({tag, " latency"}, r_lat, 9);
    chk({tag, " busy_cycles"}, r_busy, W);
    chk({tag, " done_pulses"}, r_done, 1);
    chk({tag, " sum_held"}, r_hold, v.s);
  endtask

  initial begin
    int           dt[3];
    logic [W-1:0] bs[3];
    logic [W-1:0] ba[3], bb[3];
    int           nd, nb;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset ovf", ovf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // First start is offered in the same cycle reset drops.
    for (int i = 0; i < 8; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
      check_op($sformatf("vec%0d", i), vecs[i]);
    end

    op(8'hFF, 8'hFF, 1'b1, 1'b1);
    check_op("restart_in_shift", vecs[4]);

    // Reset during the 4th SHIFT cycle.
    start = 1'b1; a = 8'h55; b = 8'h22; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst sum", sum, 0);
    chk("midrst cout", cout, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0; nb = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    chk("midrst no_done", nd, 0);
    chk("midrst no_busy", nb, 0);
    op(8'h12, 8'h34, 1'b0, 1'b0);
    check_op("after_rst", vecs[7]);

    // Back-to-back with start held high.
    ba = '{8'h01, 8'hC8, 8'h7F};
    bb = '{8'h02, 8'h64, 8'h7F};
    nd = 0;
    start = 1'b1; a = ba[0]; b = bb[0]; cin = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done && nd < 3) begin
        dt[nd] = n; bs[nd] = sum;
        nd++;
        if (nd < 3) begin a = ba[nd]; b = bb[nd]; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b done_count", nd, 3);
    if (nd == 3) begin
      chk("b2b first_latency", dt[0], 9);
      chk("b2b spacing1", dt[1] - dt[0], 10);
      chk("b2b spacing2", dt[2] - dt[1], 10);
      chk("b2b sum0", bs[0], 8'h03);
      chk("b2b sum1", bs[1], 8'h2C);
      chk("b2b sum2", bs[2], 8'hFE);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
